// File: rtl/debug_uart_tx.sv
// Snapshots debug_port1..7 on a capture pulse and sends them as one 8N1 UART packet led by SYNC_BYTE.
// Define DEBUG_UART_CHECKSUM_EN to append a ninth byte holding the XOR of bytes 1..7.
module debug_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       capture,
    input  logic [7:0] debug_port1,
    input  logic [7:0] debug_port2,
    input  logic [7:0] debug_port3,
    input  logic [7:0] debug_port4,
    input  logic [7:0] debug_port5,
    input  logic [7:0] debug_port6,
    input  logic [7:0] debug_port7,
    output logic       tx,
    output logic       busy,
    output logic       dropped,
    output logic       frame_done
);

`ifdef DEBUG_UART_CHECKSUM_EN
    localparam int unsigned NBYTES = 9;
`else
    localparam int unsigned NBYTES = 8;
`endif
    localparam int unsigned TMR_W  = $clog2(CLKS_PER_BIT);
    localparam int unsigned BIDX_W = $clog2(NBYTES);
    localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(CLKS_PER_BIT - 1);
    localparam logic [TMR_W-1:0]  TMR_PEN   = TMR_W'(CLKS_PER_BIT - 2);
    localparam logic [BIDX_W-1:0] LAST_BYTE = BIDX_W'(NBYTES - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t                  state_q, state_d;
    logic [TMR_W-1:0]        timer_q, timer_d;
    logic [2:0]              bit_idx_q, bit_idx_d;
    logic [BIDX_W-1:0]       byte_idx_q, byte_idx_d;
    logic [NBYTES-1:0][7:0]  pkt_q, pkt_d;
    logic                    tx_q, tx_d;
    logic                    busy_q, busy_d;
    logic                    dropped_q, dropped_d;
    logic                    frame_done_q, frame_done_d;
    logic [7:0]              cur_byte;
    logic                    bit_end;
    logic                    last_byte;

    // Each output is the registered value of what the line should carry during the next cycle.
    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        bit_idx_d    = bit_idx_q;
        byte_idx_d   = byte_idx_q;
        pkt_d        = pkt_q;
        tx_d         = tx_q;
        busy_d       = busy_q;
        dropped_d    = capture && busy_q;
        frame_done_d = 1'b0;
        cur_byte     = pkt_q[byte_idx_q];
        bit_end      = (timer_q == TMR_LAST);
        last_byte    = (byte_idx_q == LAST_BYTE);

        if (state_q != IDLE) begin
            timer_d = bit_end ? '0 : timer_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (capture) begin
                    pkt_d[0]   = SYNC_BYTE;
                    pkt_d[1]   = debug_port1;
                    pkt_d[2]   = debug_port2;
                    pkt_d[3]   = debug_port3;
                    pkt_d[4]   = debug_port4;
                    pkt_d[5]   = debug_port5;
                    pkt_d[6]   = debug_port6;
                    pkt_d[7]   = debug_port7;
`ifdef DEBUG_UART_CHECKSUM_EN
                    pkt_d[8]   = debug_port1 ^ debug_port2 ^ debug_port3 ^ debug_port4 ^
                                 debug_port5 ^ debug_port6 ^ debug_port7;
`endif
                    state_d    = START;
                    tx_d       = 1'b0;
                    busy_d     = 1'b1;
                    timer_d    = '0;
                    bit_idx_d  = '0;
                    byte_idx_d = '0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d   = DATA;
                    tx_d      = cur_byte[0];
                    bit_idx_d = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_idx_q == 3'd7) begin
                        state_d   = STOP;
                        tx_d      = 1'b1;
                        bit_idx_d = '0;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        tx_d      = cur_byte[bit_idx_q + 3'd1];
                    end
                end
            end
            STOP: begin
                // Raised one cycle early so the pulse sits on the final stop-bit cycle.
                if (last_byte && timer_q == TMR_PEN) begin
                    frame_done_d = 1'b1;
                end
                if (bit_end) begin
                    if (last_byte) begin
                        state_d    = IDLE;
                        busy_d     = 1'b0;
                        byte_idx_d = '0;
                    end else begin
                        state_d    = START;
                        tx_d       = 1'b0;
                        byte_idx_d = byte_idx_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            timer_q      <= '0;
            bit_idx_q    <= '0;
            byte_idx_q   <= '0;
            pkt_q        <= '0;
            tx_q         <= 1'b1;
            busy_q       <= 1'b0;
            dropped_q    <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            bit_idx_q    <= bit_idx_d;
            byte_idx_q   <= byte_idx_d;
            pkt_q        <= pkt_d;
            tx_q         <= tx_d;
            busy_q       <= busy_d;
            dropped_q    <= dropped_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign tx         = tx_q;
    assign busy       = busy_q;
    assign dropped    = dropped_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_debug_uart_tx.sv
// Directed bench for debug_uart_tx with CLKS_PER_BIT=4; outputs sampled on the falling edge.
// Honours DEBUG_UART_CHECKSUM_EN to expect the ninth checksum byte.
module tb_debug_uart_tx;

    localparam int CPB = 4;
`ifdef DEBUG_UART_CHECKSUM_EN
    localparam int NB = 9;
`else
    localparam int NB = 8;
`endif
    localparam int TOTAL = NB * 10 * CPB;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       capture = 1'b0;
    logic [7:0] debug_port1 = '0, debug_port2 = '0, debug_port3 = '0, debug_port4 = '0;
    logic [7:0] debug_port5 = '0, debug_port6 = '0, debug_port7 = '0;
    logic       tx, busy, dropped, frame_done;

    int         n_cmp = 0;
    int         n_fail = 0;

    logic [7:0] exp_bytes [0:8];
    logic [9:0] obs_frame [0:8];
    int         obs_width_bad, obs_busy_low, obs_drop_cnt, obs_drop_cyc, obs_fd_cnt, obs_fd_cyc;

    debug_uart_tx #(.CLKS_PER_BIT(CPB), .SYNC_BYTE(8'hA5)) dut (
        .clk(clk), .reset(reset), .capture(capture),
        .debug_port1(debug_port1), .debug_port2(debug_port2), .debug_port3(debug_port3),
        .debug_port4(debug_port4), .debug_port5(debug_port5), .debug_port6(debug_port6),
        .debug_port7(debug_port7),
        .tx(tx), .busy(busy), .dropped(dropped), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic load_ports(input logic [7:0] p1, p2, p3, p4, p5, p6, p7, chk);
        debug_port1 = p1; debug_port2 = p2; debug_port3 = p3; debug_port4 = p4;
        debug_port5 = p5; debug_port6 = p6; debug_port7 = p7;
        exp_bytes[0] = 8'hA5; exp_bytes[1] = p1; exp_bytes[2] = p2; exp_bytes[3] = p3;
        exp_bytes[4] = p4; exp_bytes[5] = p5; exp_bytes[6] = p6; exp_bytes[7] = p7;
        exp_bytes[8] = chk;
    endtask

    // Records one packet starting the cycle after accept; cycle k is the k-th cycle after the accept edge.
    task automatic collect_packet(input int drop_at, input int change_at, input logic [7:0] change_val);
        int k;
        obs_width_bad = 0; obs_busy_low = 0; obs_drop_cnt = 0; obs_drop_cyc = -1;
        obs_fd_cnt = 0; obs_fd_cyc = -1;
        for (int b = 0; b < NB; b++)
            for (int w = 0; w < 10; w++)
                for (int c = 0; c < CPB; c++) begin
                    @(negedge clk);
                    k = (b * 10 + w) * CPB + c;
                    if (c == 0) obs_frame[b][w] = tx;
                    else if (tx !== obs_frame[b][w]) obs_width_bad++;
                    if (busy !== 1'b1) obs_busy_low++;
                    if (dropped === 1'b1) begin obs_drop_cnt++; obs_drop_cyc = k; end
                    if (frame_done === 1'b1) begin obs_fd_cnt++; obs_fd_cyc = k; end
                    capture = (k == drop_at);
                    if (k == change_at) debug_port1 = change_val;
                end
    endtask

    task automatic test_reset;
        int bad;
        reset = 1'b1; capture = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({tx, busy, dropped, frame_done} !== 4'b1000)
            $display("[TB] FAIL reset_state: got %b expected 1000", {tx, busy, dropped, frame_done});
        reset = 1'b0;
        bad = 0;
        repeat (50) begin
            @(negedge clk);
            if ({tx, busy, dropped, frame_done} !== 4'b1000) bad++;
        end
        n_cmp++;
        if (bad !== 0) begin
            n_fail++;
            $display("[TB] FAIL reset_idle: %0d bad cycles, expected 0", bad);
        end
    endtask

    task automatic test_single_packet;
        load_ports(8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h00);
        capture = 1'b1;
        collect_packet(-1, -1, 8'h00);
        for (int b = 0; b < NB; b++) begin
            n_cmp++;
            if (obs_frame[b] !== {1'b1, exp_bytes[b], 1'b0}) begin
                n_fail++;
                $display("[TB] FAIL single_byte%0d: got %b expected %b", b, obs_frame[b], {1'b1, exp_bytes[b], 1'b0});
            end
        end
        n_cmp++;
        if (obs_width_bad !== 0) begin n_fail++; $display("[TB] FAIL single_bit_width: %0d glitches, expected 0", obs_width_bad); end
        n_cmp++;
        if (obs_busy_low !== 0) begin n_fail++; $display("[TB] FAIL single_busy: low %0d cycles, expected 0", obs_busy_low); end
        n_cmp++;
        if (obs_fd_cnt !== 1 || obs_fd_cyc !== TOTAL - 1) begin
            n_fail++;
            $display("[TB] FAIL single_frame_done: count %0d at %0d, expected 1 at %0d", obs_fd_cnt, obs_fd_cyc, TOTAL - 1);
        end
        @(negedge clk);
        n_cmp++;
        if ({tx, busy, frame_done} !== 3'b100) begin
            n_fail++;
            $display("[TB] FAIL single_after: got %b expected 100", {tx, busy, frame_done});
        end
    endtask

    task automatic test_snapshot;
        load_ports(8'h3C, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h3D);
        capture = 1'b1;
        collect_packet(-1, 5, 8'hFF);
        for (int b = 0; b < NB; b++) begin
            n_cmp++;
            if (obs_frame[b] !== {1'b1, exp_bytes[b], 1'b0}) begin
                n_fail++;
                $display("[TB] FAIL snapshot_byte%0d: got %b expected %b", b, obs_frame[b], {1'b1, exp_bytes[b], 1'b0});
            end
        end
        @(negedge clk);
    endtask

    task automatic test_drop;
        int bad;
        load_ports(8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h00);
        capture = 1'b1;
        collect_packet(100, -1, 8'h00);
        n_cmp++;
        if (obs_drop_cnt !== 1 || obs_drop_cyc !== 101) begin
            n_fail++;
            $display("[TB] FAIL drop_pulse: count %0d at %0d, expected 1 at 101", obs_drop_cnt, obs_drop_cyc);
        end
        n_cmp++;
        if (obs_frame[2] !== {1'b1, 8'h02, 1'b0} || obs_fd_cnt !== 1) begin
            n_fail++;
            $display("[TB] FAIL drop_packet: byte2 %b fd %0d, expected %b fd 1", obs_frame[2], obs_fd_cnt, {1'b1, 8'h02, 1'b0});
        end
        bad = 0;
        repeat (40) begin
            @(negedge clk);
            if ({tx, busy} !== 2'b10) bad++;
        end
        n_cmp++;
        if (bad !== 0) begin n_fail++; $display("[TB] FAIL drop_single_packet: %0d busy cycles, expected 0", bad); end

        capture = 1'b1;
        collect_packet(TOTAL - 1, -1, 8'h00);
        n_cmp++;
        if (obs_drop_cnt !== 0 || obs_fd_cyc !== TOTAL - 1) begin
            n_fail++;
            $display("[TB] FAIL drop_fd_setup: drops %0d fd at %0d, expected 0 and %0d", obs_drop_cnt, obs_fd_cyc, TOTAL - 1);
        end
        @(negedge clk);
        capture = 1'b0;
        n_cmp++;
        if ({dropped, busy, tx} !== 3'b101) begin
            n_fail++;
            $display("[TB] FAIL drop_at_frame_done: got %b expected 101", {dropped, busy, tx});
        end
        bad = 0;
        repeat (40) begin
            @(negedge clk);
            if ({tx, busy, dropped} !== 3'b100) bad++;
        end
        n_cmp++;
        if (bad !== 0) begin n_fail++; $display("[TB] FAIL drop_fd_no_packet: %0d bad cycles, expected 0", bad); end
    endtask

    task automatic test_back_to_back;
        load_ports(8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h70, 8'h00);
        capture = 1'b1;
        collect_packet(-1, -1, 8'h00);
        n_cmp++;
        if (obs_frame[7] !== {1'b1, 8'h70, 1'b0}) begin
            n_fail++;
            $display("[TB] FAIL b2b_first_byte7: got %b expected %b", obs_frame[7], {1'b1, 8'h70, 1'b0});
        end
        // The only idle cycle between packets is the accept cycle itself.
        @(negedge clk);
        n_cmp++;
        if ({tx, busy} !== 2'b10) begin n_fail++; $display("[TB] FAIL b2b_gap: got %b expected 10", {tx, busy}); end
        load_ports(8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h00);
        capture = 1'b1;
        collect_packet(-1, -1, 8'h00);
        for (int b = 0; b < NB; b++) begin
            n_cmp++;
            if (obs_frame[b] !== {1'b1, exp_bytes[b], 1'b0}) begin
                n_fail++;
                $display("[TB] FAIL b2b_byte%0d: got %b expected %b", b, obs_frame[b], {1'b1, exp_bytes[b], 1'b0});
            end
        end
        n_cmp++;
        if (obs_busy_low !== 0 || obs_fd_cyc !== TOTAL - 1) begin
            n_fail++;
            $display("[TB] FAIL b2b_second: busy low %0d fd at %0d, expected 0 and %0d", obs_busy_low, obs_fd_cyc, TOTAL - 1);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_frame;
        int bad;
        load_ports(8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h00);
        capture = 1'b1;
        @(negedge clk);
        capture = 1'b0;
        repeat (149) @(negedge clk);
        n_cmp++;
        if (tx !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_pre_reset_tx: got %b expected 0", tx); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_cmp++;
        if ({tx, busy, frame_done} !== 3'b100) begin
            n_fail++;
            $display("[TB] FAIL mid_reset_abort: got %b expected 100", {tx, busy, frame_done});
        end
        bad = 0;
        repeat (400) begin
            @(negedge clk);
            if ({tx, busy, frame_done} !== 3'b100) bad++;
        end
        n_cmp++;
        if (bad !== 0) begin n_fail++; $display("[TB] FAIL mid_no_resume: %0d bad cycles, expected 0", bad); end
        capture = 1'b1;
        collect_packet(-1, -1, 8'h00);
        for (int b = 0; b < NB; b++) begin
            n_cmp++;
            if (obs_frame[b] !== {1'b1, exp_bytes[b], 1'b0}) begin
                n_fail++;
                $display("[TB] FAIL mid_clean_byte%0d: got %b expected %b", b, obs_frame[b], {1'b1, exp_bytes[b], 1'b0});
            end
        end
        @(negedge clk);
    endtask

`ifdef DEBUG_UART_CHECKSUM_EN
    task automatic test_checksum;
        load_ports(8'h11, 8'h22, 8'h44, 8'h88, 8'h00, 8'h00, 8'h0F, 8'hF0);
        capture = 1'b1;
        collect_packet(-1, -1, 8'h00);
        n_cmp++;
        if (obs_frame[8] !== {1'b1, 8'hF0, 1'b0}) begin
            n_fail++;
            $display("[TB] FAIL checksum_f0: got %b expected %b", obs_frame[8], {1'b1, 8'hF0, 1'b0});
        end
        n_cmp++;
        if (obs_fd_cyc !== 359) begin n_fail++; $display("[TB] FAIL checksum_fd: at %0d expected 359", obs_fd_cyc); end
        @(negedge clk);
    endtask
`endif

    initial begin
        test_reset();
        test_single_packet();
        test_snapshot();
        test_drop();
        test_back_to_back();
        test_reset_mid_frame();
`ifdef DEBUG_UART_CHECKSUM_EN
        test_checksum();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
